// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-controlled ALU: opcodes, bit-timing
// derivation and the FSM state encodings.
package uart_alu_pkg;

  localparam int CLK_FREQ_HZ_DEFAULT = 50_000_000;
  localparam int BAUD_RATE_DEFAULT   = 9600;

  function automatic int clks_per_bit(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ_DEFAULT, BAUD_RATE_DEFAULT);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SHL = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_ROL = 4'h7;
  localparam logic [3:0] OP_ROR = 4'h8;

  typedef enum logic [2:0] {WAIT_OP, WAIT_A, WAIT_B, EXEC, SEND} seq_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-FF synchroniser, falling-edge start detect with mid-bit
// re-check, LSB-first data, one-clk valid pulse only when the stop bit is 1.
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronised line
// RX_START | timing to mid start bit; high there means false start
// RX_DATA  | sampling 8 data bits at mid-bit
// RX_STOP  | sampling stop bit; 1 -> valid pulse, 0 -> discard
module uart_rx
  import uart_alu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] T_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] T_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_meta, rx_s, rx_prev;
  rx_state_t     state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    idx, idx_d;
  logic [7:0]    sh, sh_d;
  logic          valid_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      state   <= RX_IDLE;
      cnt     <= '0;
      idx     <= '0;
      sh      <= '0;
      valid   <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      state   <= state_d;
      cnt     <= cnt_d;
      idx     <= idx_d;
      sh      <= sh_d;
      valid   <= valid_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    sh_d    = sh;
    valid_d = 1'b0;
    case (state)
      RX_IDLE: begin
        // edge, not level: a line stuck low after a framing error must not retrigger
        if (rx_prev && !rx_s) begin
          state_d = RX_START;
          cnt_d   = T_HALF;
        end
      end
      RX_START: begin
        if (cnt == '0) begin
          if (!rx_s) begin
            state_d = RX_DATA;
            cnt_d   = T_FULL;
            idx_d   = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == '0) begin
          sh_d  = {rx_s, sh[7:1]};
          cnt_d = T_FULL;
          if (idx == 3'd7) state_d = RX_STOP;
          else             idx_d   = idx + 1'b1;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == '0) begin
          valid_d = rx_s;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign data = sh;

endmodule

// File: rtl/top_uart_alu.sv
// UART-controlled 8-bit ALU: receives opcode, A, B as 8N1 bytes and sends
// back one result byte. Holds the sequencer, the ALU and the transmitter.
//
// state   | meaning
// WAIT_OP | waiting for the opcode byte
// WAIT_A  | waiting for operand A
// WAIT_B  | waiting for operand B
// EXEC    | one clk for the ALU result to settle on the latched operands
// SEND    | load the result into the transmitter
module top_uart_alu
  import uart_alu_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 9600
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic tx
);

  localparam int CPB = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int TCW = $clog2(CPB);
  localparam logic [TCW-1:0] T_FULL = TCW'(CPB - 1);

  function automatic logic [7:0] alu(input logic [3:0] op, input logic [7:0] a,
                                     input logic [7:0] b);
    logic [15:0] t;
    t = '0;
    case (op)
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_XOR: return a ^ b;
      OP_SHL: return (b >= 8'd8) ? 8'h00 : (a << b[2:0]);
      OP_SHR: return (b >= 8'd8) ? 8'h00 : (a >> b[2:0]);
      OP_ROL: begin
        t = {a, a} << b[2:0];
        return t[15:8];
      end
      OP_ROR: begin
        t = {a, a} >> b[2:0];
        return t[7:0];
      end
      default: return 8'h00;
    endcase
  endfunction

  logic [7:0] rx_data;
  logic       rx_valid;

  uart_rx #(.CLKS_PER_BIT(CPB)) u_rx (
    .clk   (clk),
    .rst   (rst),
    .rx    (rx),
    .data  (rx_data),
    .valid (rx_valid)
  );

  seq_state_t seq, seq_d;
  logic [3:0] op_q, op_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic       load;
  logic [7:0] result;

  assign result = alu(op_q, a_q, b_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq  <= WAIT_OP;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else begin
      seq  <= seq_d;
      op_q <= op_d;
      a_q  <= a_d;
      b_q  <= b_d;
    end
  end

  always_comb begin
    seq_d = seq;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    load  = 1'b0;
    case (seq)
      WAIT_OP: if (rx_valid) begin op_d = rx_data[3:0]; seq_d = WAIT_A; end
      WAIT_A:  if (rx_valid) begin a_d = rx_data;       seq_d = WAIT_B; end
      WAIT_B:  if (rx_valid) begin b_d = rx_data;       seq_d = EXEC;   end
      EXEC:    seq_d = SEND;
      SEND: begin
        load  = 1'b1;
        seq_d = WAIT_OP;
      end
      default: seq_d = WAIT_OP;
    endcase
  end

  // transmitter: tx comes straight from tx_q so the pin never glitches
  tx_state_t      tx_st, tx_st_d;
  logic [TCW-1:0] tx_cnt, tx_cnt_d;
  logic [2:0]     tx_idx, tx_idx_d;
  logic [7:0]     tx_sh, tx_sh_d;
  logic           tx_q, tx_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_st  <= TX_IDLE;
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh  <= '0;
      tx_q   <= 1'b1;
    end else begin
      tx_st  <= tx_st_d;
      tx_cnt <= tx_cnt_d;
      tx_idx <= tx_idx_d;
      tx_sh  <= tx_sh_d;
      tx_q   <= tx_d;
    end
  end

  always_comb begin
    tx_st_d  = tx_st;
    tx_cnt_d = tx_cnt;
    tx_idx_d = tx_idx;
    tx_sh_d  = tx_sh;
    tx_d     = tx_q;
    case (tx_st)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (load) begin
          tx_st_d  = TX_START;
          tx_cnt_d = T_FULL;
          tx_sh_d  = result;
          tx_d     = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt == '0) begin
          tx_st_d  = TX_DATA;
          tx_cnt_d = T_FULL;
          tx_idx_d = '0;
          tx_d     = tx_sh[0];
        end else begin
          tx_cnt_d = tx_cnt - 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_d = T_FULL;
          if (tx_idx == 3'd7) begin
            tx_st_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            tx_idx_d = tx_idx + 1'b1;
            tx_sh_d  = tx_sh >> 1;
            tx_d     = tx_sh[1];
          end
        end else begin
          tx_cnt_d = tx_cnt - 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == '0) tx_st_d = TX_IDLE;
        else              tx_cnt_d = tx_cnt - 1'b1;
      end
      default: begin
        tx_st_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_top_uart_alu.sv
// Directed bench for top_uart_alu at a reduced bit period; a monitor decodes
// tx frames into a queue and each triplet's result is compared to a constant.
`timescale 1ns/1ps
module tb_top_uart_alu;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic tx;

  top_uart_alu #(.CLK_FREQ_HZ(160_000), .BAUD_RATE(10_000)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .tx  (tx)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [8:0] rxq[$];
  bit         aborted = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge rst) aborted = 1'b1;

  // frame decoder; queue entries are {stop, data}
  initial begin : mon
    logic [7:0] d;
    logic       s;
    d = '0;
    forever begin
      @(negedge tx);
      aborted = 1'b0;
      repeat (CPB / 2) @(negedge clk);
      if (tx == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        s = tx;
        if (!aborted) rxq.push_back({s, d});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!stop) repeat (CPB) @(negedge clk);
  endtask

  task automatic get_result(output logic [8:0] v);
    v = 9'h000;
    for (int i = 0; i < 30 * CPB && rxq.size() == 0; i++) @(negedge clk);
    if (rxq.size() != 0) v = rxq.pop_front();
  endtask

  task automatic triplet(input string tag, input logic [7:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] r);
    logic [8:0] v;
    send_byte(op, 1'b1);
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
    get_result(v);
    chk(tag, {7'd0, v}, {7'd0, 1'b1, r});
  endtask

  task automatic count_tx_low(input int cycles, output int lows);
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
  endtask

  initial begin : main
    int         lows;
    logic [8:0] v;
    rx  = 1'b1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_tx_a", {15'd0, tx}, 16'd1);
    count_tx_low(50, lows);
    chk("rst_tx_held", 16'(lows), 16'd0);
    rst = 1'b1;
    count_tx_low(40 * CPB, lows);
    chk("idle_tx", 16'(lows), 16'd0);
    chk("idle_frames", 16'(rxq.size()), 16'd0);

    triplet("add_25_17",  8'h00, 8'd25,  8'd17,  8'd42);
    triplet("sub_60_20",  8'h01, 8'd60,  8'd20,  8'd40);
    triplet("add_wrap",   8'h00, 8'd200, 8'd100, 8'd44);
    triplet("sub_wrap",   8'h01, 8'd5,   8'd10,  8'd251);
    triplet("and",        8'h02, 8'd12,  8'd5,   8'd4);
    triplet("or",         8'h03, 8'd12,  8'd5,   8'd13);
    triplet("xor",        8'h04, 8'd12,  8'd5,   8'd9);
    triplet("shl",        8'h05, 8'd8,   8'd2,   8'd32);
    triplet("shr",        8'h06, 8'd32,  8'd2,   8'd8);
    triplet("rol",        8'h07, 8'h81,  8'd1,   8'h03);
    triplet("ror",        8'h08, 8'h81,  8'd1,   8'hC0);
    triplet("shl_big",    8'h05, 8'd1,   8'd9,   8'd0);
    triplet("shr_big",    8'h06, 8'hFF,  8'd8,   8'd0);
    triplet("op_hi_ign",  8'hF0, 8'd3,   8'd4,   8'd7);

    // short low pulse well under half a bit must not start a frame
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    chk("glitch_frames", 16'(rxq.size()), 16'd0);
    triplet("after_glitch", 8'h04, 8'hF0, 8'h0F, 8'hFF);

    send_byte(8'h00, 1'b1);
    send_byte(8'h55, 1'b0);
    send_byte(8'd30, 1'b1);
    send_byte(8'd12, 1'b1);
    get_result(v);
    chk("framing_err", {7'd0, v}, {7'd0, 1'b1, 8'd42});

    triplet("op_0f", 8'h0F, 8'd25, 8'd17, 8'h00);

    // reset while the result's data bits are on the line
    send_byte(8'h00, 1'b1);
    send_byte(8'd25, 1'b1);
    send_byte(8'd17, 1'b1);
    for (int i = 0; i < 40 * CPB && tx !== 1'b0; i++) @(negedge clk);
    chk("rtx_start", {15'd0, tx}, 16'd0);
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rtx_now", {15'd0, tx}, 16'd1);
    count_tx_low(10, lows);
    chk("rtx_hold", 16'(lows), 16'd0);
    rst = 1'b1;
    count_tx_low(20 * CPB, lows);
    chk("rtx_after", 16'(lows), 16'd0);
    chk("rtx_frames", 16'(rxq.size()), 16'd0);
    triplet("post_rst", 8'h00, 8'd1, 8'd1, 8'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
